// File: rtl/txn_rw_scheduler.sv
// Read/write drain scheduler: tracks pending reads and writes and grants the back end
// read or write issue windows, with watermark switching and a fixed bus turnaround.
module txn_rw_scheduler #(
  parameter int DEPTH        = 64,
  parameter int WR_HIGH      = 48,
  parameter int WR_LOW       = 16,
  parameter int MAX_RD_BURST = 32,
  parameter int TURN_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mapper_valid,
  input  logic       the_req_type,
  input  logic       read_issued,
  input  logic       write_issued,
  output logic       issue_read_en,
  output logic       issue_write_en,
  output logic [6:0] rd_pending,
  output logic [6:0] wr_pending,
  output logic [1:0] mode,
  output logic       err
);

  localparam int BW = $clog2(MAX_RD_BURST + 1);
  localparam int TW = $clog2(TURN_CYCLES + 1);

  localparam logic [6:0]    DEPTH_C = 7'(DEPTH);
  localparam logic [6:0]    WRHI_C  = 7'(WR_HIGH);
  localparam logic [6:0]    WRLO_C  = 7'(WR_LOW);
  localparam logic [BW-1:0] BMAX_C  = BW'(MAX_RD_BURST);
  localparam logic [TW-1:0] TLAST_C = TW'(TURN_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    TURN  = 2'b11
  } state_t;

  state_t        state, state_nx;
  state_t        target, target_nx;
  logic [TW-1:0] turn_cnt, turn_nx;
  logic [BW-1:0] rd_burst;

  logic [6:0] rd_nx, wr_nx;
  logic       rd_bad, wr_bad, err_set;

  // Returns {bounds_violation, next_count}; a simultaneous inc/dec nets to zero.
  function automatic logic [7:0] cnt_next(input logic [6:0] cur, input logic inc,
                                          input logic dec);
    logic [7:0] r;
    r = {1'b0, cur};
    if (inc && !dec) begin
      if (cur == DEPTH_C) r[7] = 1'b1;
      else                r[6:0] = cur + 7'd1;
    end else if (dec && !inc) begin
      if (cur == 7'd0) r[7] = 1'b1;
      else             r[6:0] = cur - 7'd1;
    end
    return r;
  endfunction

  always_comb begin
    {rd_bad, rd_nx} = cnt_next(rd_pending, mapper_valid & ~the_req_type, read_issued);
    {wr_bad, wr_nx} = cnt_next(wr_pending, mapper_valid &  the_req_type, write_issued);
    err_set = rd_bad | wr_bad | (read_issued & ~issue_read_en) |
              (write_issued & ~issue_write_en);
  end

  // All decisions look at the registered counts, never this cycle's inputs.
  always_comb begin
    state_nx  = state;
    target_nx = target;
    turn_nx   = turn_cnt;
    case (state)
      IDLE: begin
        if (rd_pending != 7'd0)      state_nx = READ;
        else if (wr_pending != 7'd0) state_nx = WRITE;
      end
      READ: begin
        if ((wr_pending >= WRHI_C) ||
            (wr_pending != 7'd0 && rd_burst == BMAX_C) ||
            (rd_pending == 7'd0 && wr_pending != 7'd0)) begin
          state_nx  = TURN;
          target_nx = WRITE;
          turn_nx   = '0;
        end else if (rd_pending == 7'd0 && wr_pending == 7'd0) begin
          state_nx = IDLE;
        end
      end
      WRITE: begin
        if (wr_pending == 7'd0) begin
          if (rd_pending != 7'd0) begin
            state_nx  = TURN;
            target_nx = READ;
            turn_nx   = '0;
          end else begin
            state_nx = IDLE;
          end
        end else if (wr_pending <= WRLO_C && rd_pending != 7'd0) begin
          state_nx  = TURN;
          target_nx = READ;
          turn_nx   = '0;
        end
      end
      TURN: begin
        if (turn_cnt == TLAST_C) state_nx = target;
        else                     turn_nx  = turn_cnt + TW'(1);
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      target     <= READ;
      turn_cnt   <= '0;
      rd_burst   <= '0;
      rd_pending <= 7'd0;
      wr_pending <= 7'd0;
      err        <= 1'b0;
    end else begin
      state      <= state_nx;
      target     <= target_nx;
      turn_cnt   <= turn_nx;
      rd_pending <= rd_nx;
      wr_pending <= wr_nx;
      if (err_set) err <= 1'b1;
      // Burst length restarts on every fresh read window.
      if (state_nx == READ && state != READ)
        rd_burst <= '0;
      else if (state == READ && read_issued && rd_burst != BMAX_C)
        rd_burst <= rd_burst + BW'(1);
    end
  end

  assign issue_read_en  = (state == READ);
  assign issue_write_en = (state == WRITE);
  assign mode           = state;

endmodule

// File: doc/txn_rw_scheduler.md
TXN_RW_SCHEDULER -- requirements
Module: txn_rw_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, 64, per-type queue capacity; counters saturate here.
REQ-002 SHALL have parameter WR_HIGH, 48, write-count watermark that forces a switch to write drain.
REQ-003 SHALL have parameter WR_LOW, 16, write-count watermark at which write drain ends if reads are pending.
REQ-004 SHALL have parameter MAX_RD_BURST, 32, number of reads issued before a forced switch while writes wait.
REQ-005 SHALL have parameter TURN_CYCLES, 4, bus-turnaround cycles with both issue enables low.
REQ-006 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-007 SHALL have port rst  in  1  reset; one clock; reset is synchronous and active-high.
REQ-008 SHALL have port mapper_valid  in  1  one request entered the transaction queues this cycle.
REQ-009 SHALL have port the_req_type  in  1  request type, valid with mapper_valid: 0 = read, 1 = write.
REQ-010 SHALL have port read_issued  in  1  back end issued one read this cycle.
REQ-011 SHALL have port write_issued  in  1  back end issued one write this cycle.
REQ-012 SHALL have port issue_read_en  out  1  back end is permitted to issue reads.
REQ-013 SHALL have port issue_write_en  out  1  back end is permitted to issue writes.
REQ-014 SHALL have port rd_pending  out  7  registered count of pending reads, 0..DEPTH.
REQ-015 SHALL have port wr_pending  out  7  registered count of pending writes, 0..DEPTH.
REQ-016 SHALL have port mode  out  2  current state: 00 IDLE, 01 READ, 10 WRITE, 11 TURN.
REQ-017 SHALL have port err  out  1  sticky protocol-violation flag.

Function
REQ-018 Counters SHALL update each cycle as next = cur + inc - dec; rd inc = mapper_valid & ~the_req_type, rd dec = read_issued; write likewise with the_req_type and write_issued.
REQ-019 Simultaneous inc and dec of the same counter SHALL leave it unchanged.
REQ-020 An inc at DEPTH SHALL be dropped and set err; a dec at 0 SHALL be dropped and set err.
REQ-021 read_issued while issue_read_en=0, or write_issued while issue_write_en=0, SHALL set err; the counter still decrements if nonzero.
REQ-022 issue_read_en SHALL be 1 only in READ, and issue_write_en only in WRITE; both SHALL be decoded from the registered state (Moore, no input-to-output path).
REQ-023 All transition decisions SHALL use the registered (current-cycle) counter values.
REQ-024 IDLE: go to READ if rd_pending>0; else to WRITE if wr_pending>0; else stay. There is no turnaround from IDLE.
REQ-025 READ: if wr_pending>=WR_HIGH, go to TURN with target WRITE.
REQ-026 READ: if wr_pending>0 and rd_burst==MAX_RD_BURST, go to TURN with target WRITE.
REQ-027 READ: if rd_pending==0 and wr_pending>0, go to TURN with target WRITE.
REQ-028 READ: if both counts are 0, go to IDLE; otherwise stay.
REQ-029 WRITE: if wr_pending==0, go to TURN with target READ when rd_pending>0, else go to IDLE.
REQ-030 WRITE: if wr_pending<=WR_LOW and rd_pending>0, go to TURN with target READ; otherwise stay.
REQ-031 TURN SHALL last exactly TURN_CYCLES cycles, counted by a turnaround counter, then enter the latched target, ignoring counter changes during TURN.
REQ-032 rd_burst (6+ bits) SHALL clear on every entry to READ and increment on read_issued while in READ, saturating at MAX_RD_BURST.
REQ-033 Reads SHALL have priority: when IDLE sees both counts nonzero, it goes to READ.

Reset
REQ-034 On rst=1 at a rising edge: mode=IDLE, rd_pending=0, wr_pending=0, rd_burst=0, turnaround counter=0, target=READ, err=0; issue_read_en=0 and issue_write_en=0 in the following cycle.
REQ-035 rst SHALL override all inputs in that cycle, including mid-TURN and mid-burst; inputs during reset SHALL be ignored.

Verification
REQ-036 Reset, then 3 reads (one per cycle) -> rd_pending 1,2,3; mode IDLE->READ the cycle after the first increment is registered; issue_read_en=1.
REQ-037 In READ with 5 reads pending, push 48 writes with no issues -> when wr_pending reaches 48, mode=TURN for 4 cycles with both enables 0, then WRITE.
REQ-038 In WRITE with wr_pending=20 and rd_pending=2, issue 4 writes -> at wr_pending=16, TURN (4 cycles) then READ with rd_burst=0.
REQ-039 In READ with 1 write pending and a continuous read supply, issue 32 reads -> TURN then WRITE; after the write issues, wr_pending=0 and the scheduler goes TURN then READ.
REQ-040 Same-cycle mapper_valid read plus read_issued -> rd_pending unchanged; read_issued in WRITE, or 65th read push at DEPTH -> err=1 and it stays 1 until rst.
REQ-041 Assert rst during TURN -> next cycle mode=00, both counts 0, err=0.
